// File: rtl/dsp_collect_pkg.sv
// Shared constants and width helpers for the DSP result collector.
package dsp_collect_pkg;

  // Deepest DSP pipeline the delay line supports.
  localparam int LAT_MAX   = 8;
  // Largest FIFO the collector is meant to be built with.
  localparam int DEPTH_MAX = 64;
  // Width of the in-flight counter, enough to hold 0..LAT_MAX.
  localparam int FLIGHT_W  = $clog2(LAT_MAX + 1);

  // Width of a FIFO pointer (ptr_t) for a given depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of an occupancy count (cnt_t) that must reach the full depth value.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsp_valid_delay.sv
// 1-bit valid delay line that mirrors the ce-gated DSP register pipeline.
// LATENCY=0 collapses to a wire, like a bypassed DSP stage.
module dsp_valid_delay
  import dsp_collect_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic in_bit,
  output logic out_bit
);

  // Depths beyond the supported maximum are clamped.
  localparam int LAT = (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  generate
    if (LAT == 0) begin : g_bypass
      // in_bit is already qualified by ce upstream.
      assign out_bit = in_bit;
    end else begin : g_pipe
      logic [LAT-1:0] stage_q;
      logic [LAT-1:0] stage_d;

      // Shift one stage per enabled clock, exactly like the DSP registers.
      always_comb begin
        stage_d = stage_q;
        if (ce) begin
          stage_d[0] = in_bit;
          for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
      end

      // Stage register with synchronous clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      // The result is only on dsp_p during an enabled clock.
      assign out_bit = stage_q[LAT-1] & ce;
    end
  endgenerate

endmodule

// File: rtl/dsp_result_collector.sv
// Collects DSP48A1 P results into a small FIFO and issues credit-based
// in_ready so the non-stallable pipeline can never overrun it.
// Optional sticky protocol-violation flag: define DSP_COLLECT_ERR_EN.
module dsp_result_collector
  import dsp_collect_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       dsp_p,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef DSP_COLLECT_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FLIGHT_W-1:0] in_flight_q, in_flight_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                accept;
  logic                arrive;
  logic                pop;

  // Credits come only from registered counters; a pop frees its slot next cycle.
  always_comb begin
    in_ready = !rst && ((32'(in_flight_q) + 32'(count_q)) < 32'(DEPTH));
  end

  assign accept    = in_valid & in_ready & ce;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = data_q;
  assign count     = count_q;

  dsp_valid_delay #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .in_bit  (accept),
    .out_bit (arrive)
  );

  // Next-state for pointers, counters and the registered head.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    if (arrive) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({arrive, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    unique case ({accept, arrive})
      2'b10:   in_flight_d = in_flight_q + FLIGHT_W'(1);
      2'b01:   in_flight_d = in_flight_q - FLIGHT_W'(1);
      default: in_flight_d = in_flight_q;
    endcase
    // The head after this cycle is the word being written when the FIFO
    // drains to it, otherwise the stored word at the new read pointer.
    if (arrive && (wr_ptr_q == rd_ptr_d)) begin
      data_d = dsp_p;
    end else begin
      data_d = mem[rd_ptr_d];
    end
  end

  // Result storage; never reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (arrive) begin
      mem[wr_ptr_q] <= dsp_p;
    end
  end

  // Control state with synchronous reset that discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      data_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      data_q      <= data_d;
    end
  end

`ifdef DSP_COLLECT_ERR_EN
  logic err_q, err_d;

  // Sticky flag for a beat offered while no credit was available.
  always_comb begin
    err_d = err_q | (in_valid & ce & ~in_ready);
  end

  // Flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Scoreboard bench for dsp_result_collector: a behavioural DSP pipeline feeds
// dsp_p, accepted operands are queued and compared as results are popped.
module tb_dsp_result_collector;

  localparam int W   = 48;
  localparam int LAT = 4;
  localparam int DEP = 8;

  logic         clk = 1'b0;
  logic         rst, ce, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] dsp_p, out_data;
  logic [3:0]   count;

  logic         in_valid0, in_ready0, out_valid0, out_ready0;
  logic [W-1:0] dsp_p0, out_data0;
  logic [2:0]   count0;
`ifdef DSP_COLLECT_ERR_EN
  logic         err, err0;
`endif

  always #5 clk = ~clk;

  dsp_result_collector #(.WIDTH(W), .LATENCY(LAT), .DEPTH(DEP)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dsp_p     (dsp_p),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef DSP_COLLECT_ERR_EN
    ,
    .err       (err)
`endif
  );

  dsp_result_collector #(.WIDTH(W), .LATENCY(0), .DEPTH(4)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .dsp_p     (dsp_p0),
    .out_data  (out_data0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .count     (count0)
`ifdef DSP_COLLECT_ERR_EN
    ,
    .err       (err0)
`endif
  );

  int checks = 0;
  int errors = 0;

  int           m_count;
  int           m_flight;
  bit           m_err;
  bit           m_vpipe [LAT];
  logic [W-1:0] m_dpipe [LAT];
  logic [W-1:0] exp_q [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check against the model, advance the model.
  task automatic step(input bit r, input bit c, input bit iv, input logic [W-1:0] op, input bit ordy);
    bit m_ready, acc, arr, pp;
    rst = r; ce = c; in_valid = iv; out_ready = ordy;
    #1;
    m_ready = !r && ((m_flight + m_count) < DEP);
    check_val("in_ready", in_ready, m_ready);
    check_val("out_valid", out_valid, m_count != 0);
    check_val("count", count, m_count);
`ifdef DSP_COLLECT_ERR_EN
    check_val("err", err, m_err);
`endif
    acc = iv && m_ready && c;
    arr = m_vpipe[LAT-1] && c;
    pp  = (m_count != 0) && ordy;
    if (pp) check_val("out_data", out_data, exp_q[0]);
    @(posedge clk);
    #1;
    if (c) begin
      for (int k = LAT - 1; k > 0; k--) m_dpipe[k] = m_dpipe[k-1];
      m_dpipe[0] = op;
    end
    if (r) begin
      m_count = 0; m_flight = 0; m_err = 0;
      exp_q.delete();
      for (int k = 0; k < LAT; k++) m_vpipe[k] = 1'b0;
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(op);
      m_flight += int'(acc) - int'(arr);
      m_count  += int'(arr) - int'(pp);
      if (iv && c && !m_ready) m_err = 1'b1;
      if (c) begin
        for (int k = LAT - 1; k > 0; k--) m_vpipe[k] = m_vpipe[k-1];
        m_vpipe[0] = acc;
      end
    end
    dsp_p = m_dpipe[LAT-1];
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dsp_p = '0;
    in_valid0 = 1'b0; out_ready0 = 1'b0; dsp_p0 = '0;
    m_count = 0; m_flight = 0; m_err = 1'b0;
    for (int k = 0; k < LAT; k++) begin m_vpipe[k] = 1'b0; m_dpipe[k] = '0; end
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then idle.
    repeat (2) step(1, 1, 0, '0, 0);
    repeat (8) step(0, 1, 0, '0, 1);

    // Single beat through the 4-deep pipeline.
    step(0, 1, 1, 48'h1234, 1);
    repeat (8) step(0, 1, 0, rnd(), 1);

    // Fill with no drain: only DEPTH beats may be accepted.
    repeat (14) step(0, 1, 1, rnd(), 0);
    step(0, 1, 0, rnd(), 1);
    step(0, 1, 0, rnd(), 0);
    repeat (12) step(0, 1, 0, rnd(), 1);

    // ce toggling: arrival counts enabled clocks, ce=0 offers are ignored.
    for (int i = 0; i < 12; i++) begin
      step(0, (i % 2) == 0, (i == 0) || ((i % 2) == 1), 48'hC0DE + W'(i), 1);
    end

    // Random traffic exercises simultaneous push/pop and wrap-around.
    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd(), $urandom_range(0, 2) != 0);
    end

    // Reset with beats in flight: nothing may emerge afterwards.
    repeat (10) step(0, 1, 0, rnd(), 1);
    repeat (3) step(0, 1, 1, rnd(), 0);
    step(1, 1, 0, rnd(), 0);
    repeat (8) step(0, 1, 0, rnd(), 0);

    // Zero-latency instance: result lands in the FIFO on the next clock.
    check_val("lat0_ready", in_ready0, 1'b1);
    in_valid0 = 1'b1; dsp_p0 = 48'hA5;
    step(0, 1, 0, '0, 0);
    in_valid0 = 1'b0;
    #1;
    check_val("lat0_count", count0, 3'd1);
    check_val("lat0_valid", out_valid0, 1'b1);
    check_val("lat0_data", out_data0, 48'hA5);
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; dsp_p0 = 48'hB0 + W'(i);
      step(0, 1, 0, '0, 0);
    end
    in_valid0 = 1'b0;
    #1;
    check_val("lat0_full", count0, 3'd4);
    check_val("lat0_noready", in_ready0, 1'b0);
    check_val("lat0_head", out_data0, 48'hA5);
    out_ready0 = 1'b1;
    step(0, 1, 0, '0, 0);
    out_ready0 = 1'b0;
    #1;
    check_val("lat0_popcount", count0, 3'd3);
    check_val("lat0_next", out_data0, 48'hB0);
    check_val("lat0_credit", in_ready0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
